// File: rtl/carregador_de_programa.sv
// rtl/carregador_de_programa.sv - boot-time byte-stream program loader
// Assembles little-endian words from a length-prefixed byte stream into instruction memory.
module carregador_de_programa #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst,
  output logic                  carregado,
  output logic                  erro
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DADOS,
    ESCRITA,
    FIM,
    ERRO
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  state_t                state;
  state_t                state_next;
  logic [7:0]            len_lo;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [1:0]            byte_cnt;
  logic [31:0]           shift;
  logic                  xfer;
  logic [15:0]           header_len;
  logic                  header_bad;

  assign byte_ready = !rst && ((state == LEN_LO) || (state == LEN_HI) || (state == DADOS));
  assign xfer       = byte_valid && byte_ready;
  assign header_len = {byte_in, len_lo};
  assign header_bad = (header_len == 16'd0) || ({1'b0, header_len} > MAX_WORDS);

  always_comb begin
    state_next = state;
    case (state)
      LEN_LO: begin
        if (xfer) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (xfer) state_next = header_bad ? ERRO : DADOS;
      end
      DADOS: begin
        if (xfer && (byte_cnt == 2'd3)) state_next = ESCRITA;
      end
      ESCRITA: begin
        state_next = (mem_addr == last_addr) ? FIM : DADOS;
      end
      FIM:     state_next = FIM;
      ERRO:    state_next = ERRO;
      default: state_next = LEN_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LEN_LO;
      len_lo    <= 8'd0;
      last_addr <= '0;
      byte_cnt  <= 2'd0;
      shift     <= 32'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      cpu_rst   <= 1'b1;
      carregado <= 1'b0;
      erro      <= 1'b0;
    end else begin
      state  <= state_next;
      mem_we <= 1'b0;
      case (state)
        LEN_LO: begin
          if (xfer) len_lo <= byte_in;
        end
        LEN_HI: begin
          if (xfer) begin
            byte_cnt  <= 2'd0;
            // Track the final word address rather than the count, so no extra wide counter is needed.
            last_addr <= ADDR_WIDTH'(header_len - 16'd1);
            if (header_bad) erro <= 1'b1;
          end
        end
        DADOS: begin
          if (xfer) begin
            shift    <= {byte_in, shift[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {byte_in, shift[31:8]};
            end
          end
        end
        ESCRITA: begin
          // The last address is held so a full-depth load never wraps back to zero.
          if (mem_addr == last_addr) begin
            carregado <= 1'b1;
            cpu_rst   <= 1'b0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_de_programa.sv
// tb/tb_carregador_de_programa.sv - randomized scoreboard bench for carregador_de_programa
// Expected writes are derived from the byte stream; a negedge monitor pops and compares.
module tb_carregador_de_programa;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_in = 8'd0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          carregado;
  logic          erro;

  carregador_de_programa #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .carregado  (carregado),
    .erro       (erro)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          checks = 0;
  int          errors = 0;
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  bit          spacing_on = 0;
  int          last_we_cyc = -1;
  int          n_writes = 0;
  int          mon_a;
  logic [31:0] mon_d;

  logic [7:0] prog[$] = '{8'h93, 8'h00, 8'h70, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00,
                          8'hB3, 8'h01, 8'h21, 8'h40, 8'h13, 8'h02, 8'h00, 8'h00};
  logic [7:0] beef[$] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] rnd[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the next expected word.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_writes++;
      chk("ready_low_during_write", 32'(byte_ready), 32'd0);
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %08h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_a = exp_addr.pop_front();
        mon_d = exp_data.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(mon_a));
        chk("write_data", mem_wdata, mon_d);
      end
      if (spacing_on && last_we_cyc >= 0) chk("write_spacing", 32'(cyc - last_we_cyc), 32'd5);
      last_we_cyc = cyc;
    end
  end

  function automatic logic [31:0] word_of(input logic [7:0] d[$], input int w);
    return 32'(d[4*w]) + 32'(d[4*w+1]) * 32'd256 + 32'(d[4*w+2]) * 32'd65536
         + 32'(d[4*w+3]) * 32'd16777216;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int idle_pct);
    int tries = 0;
    bit done = 0;
    byte_in = b;
    while (!done) begin
      byte_valid = ($urandom_range(99) >= idle_pct);
      @(negedge clk);
      done = byte_valid && byte_ready;
      @(posedge clk);
      #1;
      tries++;
      if (!done && tries > 200) begin
        checks++;
        errors++;
        $display("FAIL byte_accept_timeout: byte %02h not accepted, required acceptance within 200 cycles", b);
        done = 1;
      end
    end
  endtask

  task automatic load(input int n, input logic [7:0] data[$], input int idle_pct);
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(w);
      exp_data.push_back(word_of(data, w));
    end
    send_byte(8'(n), idle_pct);
    send_byte(8'(n >> 8), idle_pct);
    foreach (data[i]) send_byte(data[i], idle_pct);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!carregado && !erro && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("load_done", 32'(carregado), 32'd1);
    chk("cpu_released", 32'(cpu_rst), 32'd0);
    chk("pending_writes", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_writes = 0;
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int bad;
    int n;

    // Reset values, with a byte offered while rst is high.
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'h55;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reset_carregado", 32'(carregado), 32'd0);
    chk("reset_erro", 32'(erro), 32'd0);
    chk("reset_ready_blocked", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(byte_ready), 32'd1);
    @(posedge clk); #1;

    // Reference program, byte_valid held high.
    do_reset();
    spacing_on = 1;
    last_we_cyc = -1;
    load(4, prog, 0);
    wait_done(50);
    chk("carregado_latency", 32'(cyc - last_we_cyc), 32'd1);
    chk("prog_write_count", 32'(n_writes), 32'd4);
    spacing_on = 0;
    bad = 0;
    repeat (8) begin
      byte_valid = 1'b1;
      byte_in = 8'($urandom);
      @(negedge clk);
      if (byte_ready || !carregado || cpu_rst) bad++;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("post_load_ignored", 32'(bad), 32'd0);
    chk("post_load_writes", 32'(n_writes), 32'd4);

    // Same program with roughly half idle cycles.
    do_reset();
    load(4, prog, 50);
    wait_done(50);
    chk("idle_write_count", 32'(n_writes), 32'd4);

    // Zero-length header.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    chk("zero_len_erro", 32'(erro), 32'd1);
    chk("zero_len_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("zero_len_ready", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    bad = 0;
    repeat (100) begin
      byte_valid = 1'b1;
      byte_in = 8'($urandom);
      @(negedge clk);
      if (byte_ready || !cpu_rst || !erro || carregado) bad++;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("erro_state_sticky", 32'(bad), 32'd0);
    chk("erro_no_writes", 32'(n_writes), 32'd0);

    // N = 257 exceeds the memory depth.
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    chk("len_257_erro", 32'(erro), 32'd1);
    chk("len_257_cpu_rst", 32'(cpu_rst), 32'd1);
    @(posedge clk); #1;

    // Full-depth load of 256 random words.
    do_reset();
    rnd.delete();
    repeat (1024) rnd.push_back(8'($urandom));
    load(256, rnd, 25);
    wait_done(50);
    chk("full_write_count", 32'(n_writes), 32'd256);
    chk("full_addr_no_wrap", 32'(mem_addr), 32'd255);
    chk("full_no_erro", 32'(erro), 32'd0);

    // Reset in the middle of word 1, then a fresh one-word load.
    do_reset();
    exp_addr.push_back(0);
    exp_data.push_back(word_of(prog, 0));
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(prog[i], 0);
    rst = 1'b1;
    byte_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("abort_partial_writes", 32'(n_writes), 32'd1);
    @(posedge clk); #1;
    load(1, beef, 0);
    wait_done(50);
    chk("beef_write_count", 32'(n_writes), 32'd2);
    chk("beef_data", mem_wdata, 32'hDEADBEEF);

    // A few short random loads.
    repeat (3) begin
      do_reset();
      n = $urandom_range(5, 1);
      rnd.delete();
      repeat (4 * n) rnd.push_back(8'($urandom));
      load(n, rnd, 30);
      wait_done(50);
      chk("rand_write_count", 32'(n_writes), 32'(n));
      chk("rand_last_addr", 32'(mem_addr), 32'(n - 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
